mips_cpu_regfile_write_arbiter: RTL and testbench

Schedules writeback traffic from NUM_REQ independent producers onto the register file's two write ports (c, d). Each producer uses a valid/ready handshake. Per cycle the block grants up to two producers, round-robin fair, and never grants two writes to the same register in one cycle. Grants are registered, so the register file sees a clean, glitch-free write bundle one cycle after acceptance.

---
 rtl/mips_cpu_regfile_write_arbiter.sv | 104 ++++++++++
 tb/tb_mips_cpu_regfile_write_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Register-file writeback arbiter: up to two round-robin grants per cycle
// onto write ports c and d, with same-register conflicts deferred.
module mips_cpu_regfile_write_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hold,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*5-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [4:0]             write_addr_c,
    output logic                   write_enable_c,
    output logic [31:0]            write_data_c,
    output logic [4:0]             write_addr_d,
    output logic                   write_enable_d,
    output logic [31:0]            write_data_d,
    output logic [31:0]            pending_mask
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [4:0]       addr [NUM_REQ];
    logic [31:0]      data [NUM_REQ];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] cur;
    logic [PTR_W-1:0] idx_a;
    logic [PTR_W-1:0] idx_b;
    logic             got_a;
    logic             got_b;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr[i] = req_addr[5*i +: 5];
        assign data[i] = req_data[32*i +: 32];
    end

    function automatic logic [PTR_W-1:0] wrap(input int v);
        int w;
        w = v;
        if (w >= NUM_REQ) w = w - NUM_REQ;
        return w[PTR_W-1:0];
    endfunction

    // Rotating scan from ptr; a second grant may not hit the same
    // nonzero register as the first.
    always_comb begin
        req_ready = '0;
        got_a     = 1'b0;
        got_b     = 1'b0;
        idx_a     = '0;
        idx_b     = '0;
        cur       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cur = wrap(int'(ptr) + k);
            if (reset_n && !hold && req_valid[cur]) begin
                if (!got_a) begin
                    got_a          = 1'b1;
                    idx_a          = cur;
                    req_ready[cur] = 1'b1;
                end else if (!got_b &&
                             (addr[cur] != addr[idx_a] ||
                              addr[idx_a] == 5'd0)) begin
                    got_b          = 1'b1;
                    idx_b          = cur;
                    req_ready[cur] = 1'b1;
                end
            end
        end
        ptr_next = wrap(int'(got_b ? idx_b : idx_a) + 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr            <= '0;
            write_addr_c   <= '0;
            write_enable_c <= 1'b0;
            write_data_c   <= '0;
            write_addr_d   <= '0;
            write_enable_d <= 1'b0;
            write_data_d   <= '0;
        end else begin
            write_enable_c <= got_a && (addr[idx_a] != 5'd0);
            write_enable_d <= got_b && (addr[idx_b] != 5'd0);
            if (got_a) begin
                write_addr_c <= addr[idx_a];
                write_data_c <= data[idx_a];
                ptr          <= ptr_next;
            end
            if (got_b) begin
                write_addr_d <= addr[idx_b];
                write_data_d <= data[idx_b];
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        if (write_enable_c) pending_mask[write_addr_c] = 1'b1;
        if (write_enable_d) pending_mask[write_addr_d] = 1'b1;
    end

endmodule

// File: tb/tb_mips_cpu_regfile_write_arbiter.sv
// Randomized bench for the writeback arbiter against a queue-based
// scheduling model, plus hand-computed directed expectations.
module tb_mips_cpu_regfile_write_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [4:0]      write_addr_c;
    logic            write_enable_c;
    logic [31:0]     write_data_c;
    logic [4:0]      write_addr_d;
    logic            write_enable_d;
    logic [31:0]     write_data_d;
    logic [31:0]     pending_mask;

    mips_cpu_regfile_write_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hold(hold),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .write_addr_c(write_addr_c),
        .write_enable_c(write_enable_c),
        .write_data_c(write_data_c),
        .write_addr_d(write_addr_d),
        .write_enable_d(write_enable_d),
        .write_data_d(write_data_d),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        v [N];
    logic [4:0]  a [N];
    logic [31:0] d [N];

    int          m_ptr;
    logic        m_en_c, m_en_d;
    logic [4:0]  m_addr_c, m_addr_d;
    logic [31:0] m_data_c, m_data_d;
    logic [N-1:0] g_cur;
    int          ia_cur, ib_cur;
    int          acc_cnt [N];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = v[i];
            req_addr[5*i +: 5]  = a[i];
            req_data[32*i +: 32] = d[i];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] ad,
                           input logic [31:0] dt);
        v[i] = 1'b1;
        a[i] = ad;
        d[i] = dt;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_en_c = 0; m_en_d = 0;
        m_addr_c = '0; m_addr_d = '0;
        m_data_c = '0; m_data_d = '0;
    endtask

    // Walk producers in rotated order; take the first valid, then the
    // first later one that does not collide on a real register.
    task automatic model_grant(output logic [N-1:0] g, output int ia,
                               output int ib);
        int order [$];
        g = '0; ia = -1; ib = -1;
        if (hold || !reset_n) return;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            int i;
            i = order[j];
            if (!v[i]) continue;
            if (ia < 0) ia = i;
            else if (ib < 0 && !(a[i] == a[ia] && a[i] != 0)) ib = i;
        end
        if (ia >= 0) g[ia] = 1'b1;
        if (ib >= 0) g[ib] = 1'b1;
    endtask

    task automatic apply();
        logic [31:0] mask;
        drive();
        #1;
        model_grant(g_cur, ia_cur, ib_cur);
        check("req_ready", req_ready, g_cur);
        check("en_c", write_enable_c, m_en_c);
        check("en_d", write_enable_d, m_en_d);
        if (m_en_c) begin
            check("addr_c", write_addr_c, m_addr_c);
            check("data_c", write_data_c, m_data_c);
        end
        if (m_en_d) begin
            check("addr_d", write_addr_d, m_addr_d);
            check("data_d", write_data_d, m_data_d);
        end
        mask = (m_en_c ? 32'd1 << m_addr_c : 32'd0) |
               (m_en_d ? 32'd1 << m_addr_d : 32'd0);
        check("pending_mask", pending_mask, mask);
        check("no_dup_write", 32'(write_enable_c && write_enable_d &&
              write_addr_c == write_addr_d), 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        m_en_c = (ia_cur >= 0) && (a[ia_cur] != 0);
        m_en_d = (ib_cur >= 0) && (a[ib_cur] != 0);
        if (ia_cur >= 0) begin
            m_addr_c = a[ia_cur];
            m_data_c = d[ia_cur];
            m_ptr = ((ib_cur >= 0 ? ib_cur : ia_cur) + 1) % N;
        end
        if (ib_cur >= 0) begin
            m_addr_d = a[ib_cur];
            m_data_d = d[ib_cur];
        end
        for (int i = 0; i < N; i++)
            if (g_cur[i]) begin
                v[i] = 1'b0;
                acc_cnt[i]++;
            end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_en_c", write_enable_c, 0);
        check("rst_en_d", write_enable_d, 0);
        check("rst_addr_c", write_addr_c, 0);
        check("rst_data_d", write_data_d, 0);
        check("rst_mask", pending_mask, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        hold = 1'b0;
        clear_all();
        set_req(0, 5'd9, 32'h1234_5678);
        drive();
        model_reset();
        #1;
        check("init_ready", req_ready, '0);
        check("init_mask", pending_mask, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_all();

        set_req(0, 5'd5, 32'hDEAD_BEEF);
        apply();
        check("t1_ready", req_ready, 3'b001);
        advance();
        set_req(2, 5'd9, 32'h0000_0099);
        apply();
        check("t1_en_c", write_enable_c, 1);
        check("t1_addr_c", write_addr_c, 5);
        check("t1_data_c", write_data_c, 32'hDEAD_BEEF);
        check("t1_mask", pending_mask, 32'h20);
        check("t2_ready", req_ready, 3'b100);
        advance();

        set_req(0, 5'd3, 32'h1111_0000);
        set_req(1, 5'd4, 32'h2222_0000);
        apply();
        check("dual_ready", req_ready, 3'b011);
        advance();
        set_req(2, 5'd10, 32'h0000_00AA);
        apply();
        check("dual_c", {write_enable_c, write_addr_c, write_data_c},
              {1'b1, 5'd3, 32'h1111_0000});
        check("dual_d", {write_enable_d, write_addr_d, write_data_d},
              {1'b1, 5'd4, 32'h2222_0000});
        check("dual_ptr2", req_ready, 3'b100);
        advance();

        set_req(0, 5'd7, 32'h7777_0000);
        set_req(2, 5'd7, 32'h7777_0002);
        apply();
        check("conf_ready", req_ready, 3'b001);
        advance();
        apply();
        check("conf_ready2", req_ready, 3'b100);
        check("conf_c", {write_enable_c, write_addr_c}, {1'b1, 5'd7});
        check("conf_en_d", write_enable_d, 0);
        advance();
        apply();
        check("conf_c2", write_data_c, 32'h7777_0002);
        advance();

        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++)
                if (!v[i]) set_req(i, 5'(i + 1), $urandom);
            apply();
            case (c)
                0: check("fair0", req_ready, 3'b011);
                1: check("fair1", req_ready, 3'b101);
                default: check("fair2", req_ready, 3'b110);
            endcase
            advance();
        end
        for (int i = 0; i < N; i++) check("fair_cnt", acc_cnt[i], 2);

        clear_all();
        set_req(1, 5'd0, 32'hCAFE_0000);
        apply();
        check("z_ready", req_ready, 3'b010);
        advance();
        apply();
        check("z_en_c", write_enable_c, 0);
        check("z_mask", pending_mask, 0);
        advance();

        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), $urandom);
        apply();
        check("h_pre", req_ready, 3'b101);
        advance();
        for (int i = 0; i < N; i++)
            if (!v[i]) set_req(i, 5'(i + 1), $urandom);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply();
            check("h_ready", req_ready, '0);
            if (c == 0) begin
                check("h_drain_c", {write_enable_c, write_addr_c},
                      {1'b1, 5'd3});
                check("h_drain_d", {write_enable_d, write_addr_d},
                      {1'b1, 5'd1});
            end else begin
                check("h_off", {write_enable_c, write_enable_d}, 0);
            end
            advance();
        end
        hold = 1'b0;
        apply();
        check("h_resume", req_ready, 3'b110);
        advance();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!v[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    a[i] = 5'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            hold = ($urandom_range(0, 9) == 0);
            apply();
            advance();
            if (c == 1500) reset_pulse();
        end

        hold = 1'b0;
        clear_all();
        apply();
        advance();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
